// File: rtl/carrier_freq_meter_if.sv
// ---------------------------------------------------------------------------
// carrier_freq_meter_if
//   Bundles the carrier bus from carrier_nco together with the measurement
//   control and result signals of carrier_freq_meter.
//
//   Carrier : i_sign, i_mag, q_sign, q_mag (sign 0 = positive)
//   Control : start (one-cycle request), gate_len (samples to count)
//   Status  : busy, done (one-cycle result-valid pulse)
//   Results : phase_steps (signed quarter-cycle steps), skip_count
//             (saturating two-quadrant jumps), mag_count (i_mag=1 samples)
//
//   master : the side that drives the carrier and the control signals
//   slave  : the meter itself
// ---------------------------------------------------------------------------
interface carrier_freq_meter_if #(
   parameter int GATE_W = 24,
   parameter int STEP_W = 26,
   parameter int SKIP_W = 16
);
   logic              i_sign;
   logic              i_mag;
   logic              q_sign;
   logic              q_mag;
   logic              start;
   logic [GATE_W-1:0] gate_len;
   logic              busy;
   logic              done;
   logic [STEP_W-1:0] phase_steps;
   logic [SKIP_W-1:0] skip_count;
   logic [GATE_W-1:0] mag_count;

   modport master (
      output i_sign, i_mag, q_sign, q_mag, start, gate_len,
      input  busy, done, phase_steps, skip_count, mag_count
   );

   modport slave (
      input  i_sign, i_mag, q_sign, q_mag, start, gate_len,
      output busy, done, phase_steps, skip_count, mag_count
   );
endinterface

// File: rtl/carrier_freq_meter.sv
// ---------------------------------------------------------------------------
// carrier_freq_meter
//   Gated frequency / phase-integrity meter for the 2-bit sign/magnitude I/Q
//   carrier. Over gate_len samples it accumulates signed quarter-cycle phase
//   steps, two-quadrant skips and samples with i_mag=1.
//
//   clk  : system clock (carrier is synchronous to it)
//   rstn : asynchronous active-low reset, aborts any measurement
//   bus  : carrier_freq_meter_if slave modport (carrier in, start/gate_len
//          in, busy/done/phase_steps/skip_count/mag_count out)
//
//   Timeline for start sampled at cycle S with gate_len N:
//     S+1        ARM   : reference quadrant captured (not counted)
//     S+2..S+1+N COUNT : one sample counted per cycle
//     S+2+N      DONE  : results updated, done pulses
// ---------------------------------------------------------------------------
module carrier_freq_meter #(
   parameter int GATE_W = 24,
   parameter int STEP_W = 26,
   parameter int SKIP_W = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   carrier_freq_meter_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q,      state_d;
   logic [GATE_W-1:0] remaining_q,  remaining_d;
   logic [1:0]        prev_quad_q,  prev_quad_d;
   logic [STEP_W-1:0] acc_steps_q,  acc_steps_d;
   logic [SKIP_W-1:0] acc_skip_q,   acc_skip_d;
   logic [GATE_W-1:0] acc_mag_q,    acc_mag_d;
   logic [STEP_W-1:0] res_steps_q,  res_steps_d;
   logic [SKIP_W-1:0] res_skip_q,   res_skip_d;
   logic [GATE_W-1:0] res_mag_q,    res_mag_d;

   logic [1:0]        cur_quad;
   logic [1:0]        quad_delta;
   logic [STEP_W-1:0] steps_upd;
   logic [SKIP_W-1:0] skip_upd;
   logic [GATE_W-1:0] mag_upd;

   // q_mag carries no information the meter uses.
   logic unused_q_mag;
   assign unused_q_mag = bus.q_mag;

   // Quadrant order 0:(+,+) 1:(-,+) 2:(-,-) 3:(+,-) as (I,Q) signs.
   // Bit 1 is the Q sign, bit 0 is set when the two signs differ.
   assign cur_quad   = {bus.q_sign, bus.i_sign ^ bus.q_sign};
   assign quad_delta = cur_quad - prev_quad_q;   // modulo-4 by width

   // Accumulator values after counting the current sample.
   always_comb begin
      steps_upd = acc_steps_q;
      skip_upd  = acc_skip_q;
      case (quad_delta)
         2'd1:    steps_upd = acc_steps_q + STEP_W'(1);
         2'd3:    steps_upd = acc_steps_q - STEP_W'(1);
         2'd2:    if (acc_skip_q != {SKIP_W{1'b1}}) skip_upd = acc_skip_q + SKIP_W'(1);
         default: ;
      endcase
      mag_upd = acc_mag_q + GATE_W'(bus.i_mag);
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      prev_quad_d = prev_quad_q;
      acc_steps_d = acc_steps_q;
      acc_skip_d  = acc_skip_q;
      acc_mag_d   = acc_mag_q;
      res_steps_d = res_steps_q;
      res_skip_d  = res_skip_q;
      res_mag_d   = res_mag_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d     = ST_ARM;
               remaining_d = bus.gate_len;
               acc_steps_d = '0;
               acc_skip_d  = '0;
               acc_mag_d   = '0;
            end
         end
         ST_ARM: begin
            prev_quad_d = cur_quad;
            if (remaining_q == '0) begin
               // Empty gate: publish the freshly cleared accumulators.
               state_d     = ST_DONE;
               res_steps_d = acc_steps_q;
               res_skip_d  = acc_skip_q;
               res_mag_d   = acc_mag_q;
            end else begin
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            prev_quad_d = cur_quad;
            acc_steps_d = steps_upd;
            acc_skip_d  = skip_upd;
            acc_mag_d   = mag_upd;
            remaining_d = remaining_q - GATE_W'(1);
            if (remaining_q == GATE_W'(1)) begin
               // Last sample: results include it.
               state_d     = ST_DONE;
               res_steps_d = steps_upd;
               res_skip_d  = skip_upd;
               res_mag_d   = mag_upd;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         prev_quad_q <= '0;
         acc_steps_q <= '0;
         acc_skip_q  <= '0;
         acc_mag_q   <= '0;
         res_steps_q <= '0;
         res_skip_q  <= '0;
         res_mag_q   <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         prev_quad_q <= prev_quad_d;
         acc_steps_q <= acc_steps_d;
         acc_skip_q  <= acc_skip_d;
         acc_mag_q   <= acc_mag_d;
         res_steps_q <= res_steps_d;
         res_skip_q  <= res_skip_d;
         res_mag_q   <= res_mag_d;
      end
   end

   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.phase_steps = res_steps_q;
   assign bus.skip_count  = res_skip_q;
   assign bus.mag_count   = res_mag_q;

endmodule

// File: tb/tb_carrier_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_carrier_freq_meter
//   Directed measurements against carrier_freq_meter. A cycle-level model
//   records the sampled quadrants of each gate and derives the results from
//   the quadrant sequence; outputs are compared on every falling edge, and
//   each measurement is also pinned by hand-computed literals.
// ---------------------------------------------------------------------------
module tb_carrier_freq_meter;

   localparam int GATE_W = 24;
   localparam int STEP_W = 26;
   localparam int SKIP_W = 16;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   carrier_freq_meter_if #(.GATE_W(GATE_W), .STEP_W(STEP_W), .SKIP_W(SKIP_W)) bus_if ();

   carrier_freq_meter #(.GATE_W(GATE_W), .STEP_W(STEP_W), .SKIP_W(SKIP_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit                m_active;
   int                m_p;
   int                m_n;
   int                mq[$];
   bit                mm[$];
   bit                e_busy;
   bit                e_done;
   logic [STEP_W-1:0] e_steps;
   logic [SKIP_W-1:0] e_skip;
   logic [GATE_W-1:0] e_mag;

   function automatic int quad_of(input logic is, input logic qs);
      if (!is && !qs)      return 0;
      else if (is && !qs)  return 1;
      else if (is && qs)   return 2;
      else                 return 3;
   endfunction

   task automatic model_reset();
      m_active = 0;
      e_busy   = 0;
      e_done   = 0;
      e_steps  = '0;
      e_skip   = '0;
      e_mag    = '0;
   endtask

   task automatic model_results();
      int steps = 0;
      int skips = 0;
      int mags  = 0;
      for (int i = 1; i < mq.size(); i++) begin
         int d;
         d = (mq[i] - mq[i-1] + 4) % 4;
         if (d == 1) steps++;
         else if (d == 3) steps--;
         else if (d == 2) skips++;
         if (mm[i]) mags++;
      end
      e_steps = STEP_W'(steps);
      e_skip  = (skips >= (1 << SKIP_W) - 1) ? {SKIP_W{1'b1}} : SKIP_W'(skips);
      e_mag   = GATE_W'(mags);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rstn) begin
            model_reset();
         end else if (!m_active) begin
            e_busy = 0;
            e_done = 0;
            if (bus_if.start) begin
               m_active = 1;
               m_p      = 1;
               m_n      = int'(bus_if.gate_len);
               mq.delete();
               mm.delete();
               e_busy   = 1;
            end
         end else begin
            if (m_p <= m_n + 1) begin
               mq.push_back(quad_of(bus_if.i_sign, bus_if.q_sign));
               mm.push_back(bus_if.i_mag);
            end
            m_p++;
            if (m_p == m_n + 2) begin
               model_results();
               e_done = 1;
            end else if (m_p == m_n + 3) begin
               m_active = 0;
               e_busy   = 0;
               e_done   = 0;
            end
         end
         @(negedge clk);
         if (!rstn) model_reset();
         check("busy",        bus_if.busy,        e_busy);
         check("done",        bus_if.done,        e_done);
         check("phase_steps", bus_if.phase_steps, e_steps);
         check("skip_count",  bus_if.skip_count,  e_skip);
         check("mag_count",   bus_if.mag_count,   e_mag);
      end
   end

   // ---------------- stimulus ----------------
   // j = -1 is the start cycle, j = 0 the reference sample, j >= 1 counted.
   task automatic drive(input int pat, input int j);
      int q;
      bit m;
      q = 0;
      m = 0;
      if (j >= 0) begin
         case (pat)
            0: q = j % 4;                         // forward, one step per clock
            1: q = (4 - ((j / 2) % 4)) % 4;       // reverse, each quadrant held 2
            2: begin q = (j % 2) * 2; m = (j % 3 == 0); end  // skips
            default: q = 0;
         endcase
      end
      bus_if.i_sign = (q == 1) || (q == 2);
      bus_if.q_sign = (q >= 2);
      bus_if.i_mag  = m;
      bus_if.q_mag  = ~m;
   endtask

   task automatic measure(input int n, input int pat, input int restart_at,
                          input int abort_at, output int done_lat);
      int  s;
      int  j;
      bit  seen;
      s        = cyc;
      j        = -1;
      seen     = 0;
      done_lat = -1;
      bus_if.gate_len = GATE_W'(n);
      while (!seen && j < n + 8) begin
         drive(pat, j);
         bus_if.start = (j == -1) || (j == restart_at);
         @(posedge clk);
         #1;
         j++;
         if (j == abort_at) begin
            rstn         = 1'b0;
            bus_if.start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("abort_busy",  bus_if.busy,        0);
            check("abort_steps", bus_if.phase_steps, 0);
            rstn = 1'b1;
            $display("measure N=%0d aborted by reset at sample %0d", n, abort_at);
            return;
         end
         if (bus_if.done) begin
            seen     = 1;
            done_lat = cyc - s;
         end
      end
      bus_if.start = 1'b0;
      if (!seen) check("done_timeout", 0, 1);
      $display("measure N=%0d done after %0d cycles steps=0x%0h skip=0x%0h mag=%0d",
               n, done_lat, bus_if.phase_steps, bus_if.skip_count, bus_if.mag_count);
      // Step past the DONE cycle so the next start is accepted.
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      bus_if.i_sign   = 0;
      bus_if.i_mag    = 0;
      bus_if.q_sign   = 0;
      bus_if.q_mag    = 0;
      bus_if.start    = 0;
      bus_if.gate_len = '0;

      // Reset held: toggle everything, nothing may move.
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         bus_if.start    = k[0];
         bus_if.i_sign   = k[1];
         bus_if.q_sign   = k[0];
         bus_if.i_mag    = 1'b1;
         bus_if.gate_len = GATE_W'(k);
         check("rst_busy", bus_if.busy, 0);
      end
      bus_if.start = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;

      measure(0, 0, -1, -1, lat);
      check("n0_latency", lat, 2);
      check("n0_steps", bus_if.phase_steps, 0);
      check("n0_mag",   bus_if.mag_count,   0);

      measure(100, 0, 50, -1, lat);
      check("fwd_latency", lat, 102);
      check("fwd_steps", bus_if.phase_steps, 100);
      check("fwd_skip",  bus_if.skip_count,  0);

      measure(40, 1, -1, -1, lat);
      check("rev_latency", lat, 42);
      check("rev_steps", bus_if.phase_steps, 26'h3FFFFEC);

      measure(30, 2, -1, -1, lat);
      check("skip_latency", lat, 32);
      check("skip_skip",  bus_if.skip_count,  30);
      check("skip_steps", bus_if.phase_steps, 0);
      check("skip_mag",   bus_if.mag_count,   10);

      measure(40, 0, -1, 20, lat);
      check("abort_skip", bus_if.skip_count, 0);

      measure(40, 1, -1, -1, lat);
      check("rev2_steps", bus_if.phase_steps, 26'h3FFFFEC);

      measure(65540, 2, -1, -1, lat);
      check("sat_latency", lat, 65542);
      check("sat_skip",  bus_if.skip_count,  16'hFFFF);
      check("sat_steps", bus_if.phase_steps, 0);
      check("sat_mag",   bus_if.mag_count,   21846);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
